tdes_ahb_slave_regs: RTL and testbench

//  Parametrised AHB-Lite slave register front-end for the Triple DES core.
//  - Decodes a word-addressed register map: control, status, NUM_KEYS keys, input block, output block.
//  - Issues a one-cycle start to the cipher engine and captures its result.
//  - Inserts wait states on result reads while the engine is busy.
//  - Returns the proper two-cycle AHB ERROR response for illegal accesses.

---
 rtl/tdes_ahb_slave_regs_pkg.sv | 43 ++++
 rtl/tdes_ahb_slave_regs.sv | 219 +++++++++++++++++++++
 tb/tb_tdes_ahb_slave_regs.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdes_ahb_slave_regs_pkg.sv
// ---------------------------------------------------------------------------
// tdes_ahb_pkg
//   Shared types and constants for the Triple DES AHB-Lite register front-end:
//   HTRANS encoding, slave FSM state codes, register index map (as functions
//   of the key count) and CTRL/STATUS bit positions.
// ---------------------------------------------------------------------------
package tdes_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    // Slave FSM state codes
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DATA  = 3'd1;
    localparam logic [2:0] ST_STALL = 3'd2;
    localparam logic [2:0] ST_ERR1  = 3'd3;
    localparam logic [2:0] ST_ERR2  = 3'd4;

    // Register word indices
    localparam int IDX_CTRL   = 0;
    localparam int IDX_STATUS = 1;
    localparam int IDX_KEY0   = 2;

    function automatic int idx_din(input int num_keys);
        return num_keys + 2;
    endfunction

    function automatic int idx_dout(input int num_keys);
        return num_keys + 3;
    endfunction

    // CTRL / STATUS bit positions
    localparam int CTRL_MODE_BIT  = 0;
    localparam int CTRL_START_BIT = 1;
    localparam int CTRL_IRQEN_BIT = 2;
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;

endpackage

// File: rtl/tdes_ahb_slave_regs.sv
// ---------------------------------------------------------------------------
// tdes_ahb_slave_regs
//   AHB-Lite slave register front-end for the Triple DES core. Decodes the
//   word-addressed map (CTRL, STATUS, KEY[0..NUM_KEYS-1], DIN, DOUT), pulses
//   eng_start, captures eng_dout on eng_done, stalls DOUT reads while the
//   engine is busy and returns the two-cycle ERROR response.
//
//   Optional feature macro: TDES_IRQ_EN (adds the irq port and CTRL.irq_en).
//
// Ports
//   HCLK, HRESET          bus clock, synchronous active-high reset
//   HSEL..HWDATA          AHB-Lite slave inputs
//   HRDATA, HREADYOUT,    AHB-Lite slave outputs
//   HRESP
//   eng_start, eng_mode,  engine command: start pulse, 1=encrypt, keys
//   eng_key, eng_din      (key0 in LSBs), input block
//   eng_done, eng_dout    engine result pulse and data
//   irq                   level interrupt (TDES_IRQ_EN only)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no data phase in progress
// DATA  | zero-wait data phase of an accepted legal transfer
// STALL | DOUT read waiting for the engine result (HREADYOUT=0)
// ERR1  | first ERROR cycle (HRESP=1, HREADYOUT=0)
// ERR2  | second ERROR cycle (HRESP=1, HREADYOUT=1)
// ---------------------------------------------------------------------------
module tdes_ahb_slave_regs
    import tdes_ahb_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 12,
    parameter int NUM_KEYS = 3
) (
    input  logic                       HCLK,
    input  logic                       HRESET,
    input  logic                       HSEL,
    input  logic [ADDR_W-1:0]          HADDR,
    input  logic [1:0]                 HTRANS,
    input  logic                       HWRITE,
    input  logic [2:0]                 HSIZE,
    input  logic                       HREADY,
    input  logic [DATA_W-1:0]          HWDATA,
    output logic [DATA_W-1:0]          HRDATA,
    output logic                       HREADYOUT,
    output logic                       HRESP,
    output logic                       eng_start,
    output logic                       eng_mode,
    output logic [NUM_KEYS*DATA_W-1:0] eng_key,
    output logic [DATA_W-1:0]          eng_din,
    input  logic                       eng_done,
    input  logic [DATA_W-1:0]          eng_dout
`ifdef TDES_IRQ_EN
    ,
    output logic                       irq
`endif
);

    localparam int BSH   = $clog2(DATA_W / 8);
    localparam int IDX_W = ADDR_W - BSH;

    localparam logic [2:0]       SIZE_OK  = 3'(BSH);
    localparam logic [IDX_W-1:0] I_CTRL   = IDX_W'(IDX_CTRL);
    localparam logic [IDX_W-1:0] I_STATUS = IDX_W'(IDX_STATUS);
    localparam logic [IDX_W-1:0] I_KEY0   = IDX_W'(IDX_KEY0);
    localparam logic [IDX_W-1:0] I_KEYN   = IDX_W'(IDX_KEY0 + NUM_KEYS - 1);
    localparam logic [IDX_W-1:0] I_DIN    = IDX_W'(idx_din(NUM_KEYS));
    localparam logic [IDX_W-1:0] I_DOUT   = IDX_W'(idx_dout(NUM_KEYS));

    logic [2:0]        state_q, state_d;
    logic              wr_q;
    logic [IDX_W-1:0]  idx_q;
    logic              mode_q, busy_q, done_q, start_q;
    logic              irq_en_q;
    logic [DATA_W-1:0] key_q [NUM_KEYS];
    logic [DATA_W-1:0] din_q, dout_q;

    htrans_t          trans;
    logic [IDX_W-1:0] a_idx;
    logic             a_ph, accept, a_err, a_stall;
    logic             wr_act, start_wr, busy_eff, eng_cap;
    logic             unused_addr_lsb;

    assign trans           = htrans_t'(HTRANS);
    assign a_idx           = HADDR[ADDR_W-1:BSH];
    assign unused_addr_lsb = ^HADDR[BSH-1:0];

    assign a_ph   = HSEL && HREADY && (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);
    assign accept = a_ph && (state_q != ST_STALL) && (state_q != ST_ERR1);

    assign wr_act   = (state_q == ST_DATA) && wr_q;
    assign start_wr = wr_act && (idx_q == I_CTRL) && HWDATA[CTRL_START_BIT] && !busy_q;
    assign eng_cap  = busy_q && eng_done;

    // A start written in the current data phase makes the engine busy for
    // the transfer whose address phase overlaps it.
    assign busy_eff = busy_q || start_wr;

    assign a_err = (HSIZE != SIZE_OK)
                || (a_idx > I_DOUT)
                || (HWRITE && a_idx == I_DOUT)
                || (HWRITE && busy_eff &&
                    (a_idx == I_CTRL || a_idx == I_DIN ||
                     (a_idx >= I_KEY0 && a_idx <= I_KEYN)));

    // A result landing in this very cycle is captured before the data phase,
    // so that read completes without waiting.
    assign a_stall = !HWRITE && (a_idx == I_DOUT) && busy_eff && !eng_cap;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STALL: if (eng_cap || !busy_q) state_d = ST_DATA;
            ST_ERR1:  state_d = ST_ERR2;
            default: begin
                if (accept) begin
                    if (a_err)        state_d = ST_ERR1;
                    else if (a_stall) state_d = ST_STALL;
                    else              state_d = ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= ST_IDLE;
            wr_q     <= 1'b0;
            idx_q    <= '0;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
            din_q    <= '0;
            dout_q   <= '0;
            for (int i = 0; i < NUM_KEYS; i++) key_q[i] <= '0;
`ifdef TDES_IRQ_EN
            irq_en_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            start_q <= 1'b0;

            if (accept) begin
                wr_q  <= HWRITE;
                idx_q <= a_idx;
            end

            if (wr_act) begin
                if (idx_q == I_CTRL && !busy_q) begin
                    mode_q <= HWDATA[CTRL_MODE_BIT];
`ifdef TDES_IRQ_EN
                    irq_en_q <= HWDATA[CTRL_IRQEN_BIT];
`endif
                end
                if (idx_q == I_STATUS && HWDATA[STAT_DONE_BIT]) done_q <= 1'b0;
                if (idx_q == I_DIN) din_q <= HWDATA;
                for (int i = 0; i < NUM_KEYS; i++) begin
                    if (idx_q == I_KEY0 + IDX_W'(i)) key_q[i] <= HWDATA;
                end
            end

            if (start_wr) begin
                start_q <= 1'b1;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
            end

            // Placed after the W1C so a coincident result keeps done set.
            if (eng_cap) begin
                dout_q <= eng_dout;
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

`ifdef TDES_IRQ_EN
    always_ff @(posedge HCLK) begin
        if (HRESET) irq <= 1'b0;
        else        irq <= done_q && irq_en_q;
    end
`else
    assign irq_en_q = 1'b0;
`endif

    always_comb begin
        HRDATA = '0;
        if (state_q == ST_DATA && !wr_q) begin
            if (idx_q == I_CTRL) begin
                HRDATA[CTRL_MODE_BIT]  = mode_q;
                HRDATA[CTRL_IRQEN_BIT] = irq_en_q;
            end
            if (idx_q == I_STATUS) begin
                HRDATA[STAT_BUSY_BIT] = busy_q;
                HRDATA[STAT_DONE_BIT] = done_q;
            end
            if (idx_q == I_DIN)  HRDATA = din_q;
            if (idx_q == I_DOUT) HRDATA = dout_q;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (idx_q == I_KEY0 + IDX_W'(i)) HRDATA = key_q[i];
            end
        end
    end

    always_comb begin
        eng_key = '0;
        for (int i = 0; i < NUM_KEYS; i++) eng_key[i*DATA_W +: DATA_W] = key_q[i];
    end

    assign HREADYOUT = !(state_q == ST_STALL || state_q == ST_ERR1);
    assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign eng_start = start_q;
    assign eng_mode  = mode_q;
    assign eng_din   = din_q;

endmodule

// File: tb/tb_tdes_ahb_slave_regs.sv
// ---------------------------------------------------------------------------
// tb_tdes_ahb_slave_regs
//   Scoreboard bench for tdes_ahb_slave_regs (DATA_W=64, ADDR_W=12,
//   NUM_KEYS=3). The bench acts as single master and as the cipher engine.
//   Expected responses come from a register-level reference model and are
//   queued at issue; bus and engine monitors pop and compare.
// ---------------------------------------------------------------------------
module tb_tdes_ahb_slave_regs;

    localparam int K = 3;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          HSEL;
    logic [11:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic          HREADY;
    logic [63:0]   HWDATA;
    logic [63:0]   HRDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic          eng_start;
    logic          eng_mode;
    logic [191:0]  eng_key;
    logic [63:0]   eng_din;
    logic          eng_done;
    logic [63:0]   eng_dout;
`ifdef TDES_IRQ_EN
    logic          irq;
`endif

    tdes_ahb_slave_regs #(.DATA_W(64), .ADDR_W(12), .NUM_KEYS(K)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .eng_start(eng_start), .eng_mode(eng_mode), .eng_key(eng_key),
        .eng_din(eng_din), .eng_done(eng_done), .eng_dout(eng_dout)
`ifdef TDES_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;   // single slave on the bus

    typedef struct {
        bit          is_read;
        bit          err;
        int          waits;
        logic [63:0] rdata;
        int          tag;
    } exp_t;

    typedef struct {
        logic         mode;
        logic [63:0]  din;
        logic [191:0] key;
    } start_t;

    exp_t   exp_q[$];
    start_t start_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int tag_cnt  = 0;

    // reference model
    logic [63:0] m_key [4];
    logic [63:0] m_din, m_dout;
    logic        m_mode, m_irqen, m_busy, m_done;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    function automatic logic [191:0] m_keys();
        logic [191:0] kp = '0;
        for (int i = 0; i < K; i++) kp[i*64 +: 64] = m_key[i];
        return kp;
    endfunction

    function automatic logic [63:0] model_read(input int idx);
        logic [63:0] r = '0;
        if (idx == 0) begin r[0] = m_mode; r[2] = m_irqen; end
        else if (idx == 1) begin r[0] = m_busy; r[1] = m_done; end
        else if (idx <= K + 1) r = m_key[idx-2];
        else if (idx == K + 2) r = m_din;
        else r = m_dout;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_key[i] = '0;
        m_din = '0; m_dout = '0; m_mode = 0; m_irqen = 0; m_busy = 0; m_done = 0;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge HCLK);
        while (!HREADY && n < 200) begin n++; @(negedge HCLK); end
        if (!HREADY) begin
            n_checks++; n_fail++;
            $display("FAIL bus_timeout: HREADY still %0b after 200 cycles, required 1", HREADY);
            summary();
            $fatal(1, "bus timeout");
        end
    endtask

    // One AHB transfer; returns once its address phase is accepted (or, for a
    // stalled DOUT read, once the engine result has been delivered).
    task automatic issue(input bit wr, input int idx, input logic [63:0] wd,
                         input logic [2:0] sz, input int lat, input logic [63:0] ev);
        exp_t   e;
        start_t s;
        bit     stall = 0;
        e.is_read = !wr; e.waits = 0; e.rdata = '0; e.tag = tag_cnt++;
        e.err = (sz != 3'd3) || (idx > K + 3) || (wr && idx == K + 3) ||
                (wr && m_busy && (idx == 0 || (idx >= 2 && idx <= K + 2)));
        if (!e.err) begin
            if (wr) begin
                if (idx == 0) begin
                    m_mode = wd[0];
`ifdef TDES_IRQ_EN
                    m_irqen = wd[2];
`endif
                    if (wd[1]) begin
                        m_busy = 1; m_done = 0;
                        s.mode = wd[0]; s.din = m_din; s.key = m_keys();
                        start_q.push_back(s);
                    end
                end else if (idx == 1) begin
                    if (wd[1]) m_done = 0;
                end else if (idx <= K + 1) m_key[idx-2] = wd;
                else if (idx == K + 2) m_din = wd;
            end else begin
                if (idx == K + 3 && m_busy) begin
                    stall = 1; e.waits = lat;
                    m_dout = ev; m_busy = 0; m_done = 1;
                end
                e.rdata = model_read(idx);
            end
        end
        exp_q.push_back(e);

        HSEL = 1; HTRANS = 2'b10; HWRITE = wr; HADDR = 12'(idx * 8); HSIZE = sz;
        wait_ready();
        @(posedge HCLK); #1;
        HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = wd;
        if (stall) begin
            repeat (lat - 1) begin @(posedge HCLK); #1; end
            eng_done = 1; eng_dout = ev;
            @(posedge HCLK); #1;
            eng_done = 0; eng_dout = {$urandom, $urandom};
        end
    endtask

    task automatic wr_reg(input int idx, input logic [63:0] d);
        issue(1, idx, d, 3'd3, 1, 64'h0);
    endtask

    task automatic rd_reg(input int idx);
        issue(0, idx, {$urandom, $urandom}, 3'd3, 1, 64'h0);
    endtask

    task automatic fire_done(input logic [63:0] v);
        @(posedge HCLK); #1;
        eng_done = 1; eng_dout = v;
        @(posedge HCLK); #1;
        eng_done = 0;
        if (m_busy) begin m_dout = v; m_busy = 0; m_done = 1; end
    endtask

    // bus monitor
    bit   in_data = 0;
    int   waits = 0;
    logic first_resp;
    always @(negedge HCLK) begin
        exp_t e;
        if (HRESET) begin
            in_data = 0;
        end else begin
            if (in_data) begin
                if (waits == 0) first_resp = HRESP;
                if (HREADYOUT) begin
                    in_data = 0;
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_xfer: got a completed transfer, required none");
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("resp#%0d", e.tag), HRESP, e.err);
                        chk($sformatf("resp_first#%0d", e.tag), first_resp, e.err);
                        chk($sformatf("waits#%0d", e.tag), waits, e.err ? 1 : e.waits);
                        if (e.is_read && !e.err)
                            chk($sformatf("rdata#%0d", e.tag), HRDATA, e.rdata);
                    end
                end else begin
                    waits++;
                end
            end
            if (HSEL && HTRANS[1] && HREADY) begin
                in_data = 1; waits = 0;
            end
        end
    end

    // engine command monitor
    int start_run = 0;
    always @(negedge HCLK) begin
        start_t s;
        if (HRESET) begin
            start_run = 0;
        end else if (eng_start) begin
            if (start_run == 0) begin
                if (start_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_start: got eng_start=1, required 0");
                end else begin
                    s = start_q.pop_front();
                    chk("eng_mode", eng_mode, s.mode);
                    chk("eng_din", eng_din, s.din);
                    chk("eng_key", eng_key, s.key);
                end
            end
            start_run++;
        end else if (start_run != 0) begin
            chk("start_width", start_run, 1);
            start_run = 0;
        end
    end

    initial begin
        #3_000_000;
        n_checks++; n_fail++;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        int op, idx;
        logic [63:0] v;

        HRESET = 1; HSEL = 0; HADDR = '0; HTRANS = 2'b00; HWRITE = 0; HSIZE = 3'd3;
        HWDATA = '0; eng_done = 0; eng_dout = '0;
        model_reset();
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_hrdata", HRDATA, 64'h0);
        chk("rst_hreadyout", HREADYOUT, 1'b1);
        chk("rst_hresp", HRESP, 1'b0);
        chk("rst_eng_start", eng_start, 1'b0);
        chk("rst_eng_mode", eng_mode, 1'b0);
        chk("rst_eng_key", eng_key, 192'h0);
        chk("rst_eng_din", eng_din, 64'h0);
        @(posedge HCLK); #1;
        HRESET = 0;
        for (int i = 0; i <= K + 3; i++) rd_reg(i);

        // keys
        wr_reg(2, 64'h0123456789ABCDEF);
        wr_reg(3, 64'h23456789ABCDEF01);
        wr_reg(4, 64'h456789ABCDEF0123);
        rd_reg(2); rd_reg(3); rd_reg(4);

        // start, status, stalled DOUT read
        wr_reg(K + 2, 64'h4E6F772069732074);
        wr_reg(0, 64'h3);
        rd_reg(1);
        issue(0, K + 3, 64'h0, 3'd3, 5, 64'h3FA40E8A984D4815);
        rd_reg(1);

        // illegal index, then a normal read
        wr_reg(K + 4, 64'hDEAD);
        rd_reg(2);

        // writes while busy, W1C of done
        wr_reg(0, 64'h2);
        wr_reg(3, 64'hFFFF_0000_FFFF_0000);
        wr_reg(0, 64'h1);
        wr_reg(K + 2, 64'h1111);
        rd_reg(3);
        rd_reg(1);
        fire_done(64'hA5A5_5A5A_0F0F_F0F0);
        rd_reg(1);
        rd_reg(K + 3);
        wr_reg(1, 64'h2);
        rd_reg(1);

        // DOUT write error, HSIZE mismatch
        wr_reg(K + 3, 64'h1234);
        issue(0, 2, 64'h0, 3'd2, 1, 64'h0);
        issue(1, 2, 64'h77, 3'd0, 1, 64'h0);
        rd_reg(2);

        // W1C coinciding with engine result: set wins
        wr_reg(0, 64'h2);
        wr_reg(1, 64'h2);
        eng_done = 1; eng_dout = 64'hCAFE_F00D_1234_5678;
        @(posedge HCLK); #1;
        eng_done = 0;
        m_dout = 64'hCAFE_F00D_1234_5678; m_busy = 0; m_done = 1;
        rd_reg(1);
        rd_reg(K + 3);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 9);
            v  = {$urandom, $urandom};
            case (op)
                0, 1, 2: wr_reg($urandom_range(0, K + 2), v);
                3, 4, 5: begin
                    idx = $urandom_range(0, K + 3);
                    issue(0, idx, v, 3'd3, $urandom_range(1, 6), {$urandom, $urandom});
                end
                6: begin
                    idx = ($urandom_range(0, 3) == 0) ? 511 : $urandom_range(K + 4, K + 20);
                    issue($urandom_range(0, 1), idx, v, 3'd3, 1, 64'h0);
                end
                7: wr_reg($urandom_range(0, 1) ? 1 : K + 3, v);
                8: begin
                    if (m_busy) fire_done(v);
                    else begin @(posedge HCLK); #1; end
                end
                default: issue($urandom_range(0, 1), $urandom_range(0, K + 3), v,
                               3'($urandom_range(0, 2)), 1, 64'h0);
            endcase
        end

        // reset during a DOUT stall
        if (m_busy) fire_done(64'h0);
        wr_reg(0, 64'h3);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = 12'((K + 3) * 8); HSIZE = 3'd3;
        wait_ready();
        @(posedge HCLK); #1;
        HSEL = 0; HTRANS = 2'b00;
        @(negedge HCLK);
        chk("stall_hreadyout", HREADYOUT, 1'b0);
        @(posedge HCLK); #1;
        HRESET = 1;
        @(posedge HCLK); #1;
        HRESET = 0;
        exp_q.delete();
        model_reset();
        @(negedge HCLK);
        chk("rst2_hreadyout", HREADYOUT, 1'b1);
        chk("rst2_hresp", HRESP, 1'b0);
        chk("rst2_hrdata", HRDATA, 64'h0);
        chk("rst2_eng_start", eng_start, 1'b0);
        chk("rst2_eng_mode", eng_mode, 1'b0);
        chk("rst2_eng_key", eng_key, 192'h0);
        chk("rst2_eng_din", eng_din, 64'h0);
        @(posedge HCLK); #1;
        eng_done = 1; eng_dout = 64'hBAD0_BAD0_BAD0_BAD0;
        @(posedge HCLK); #1;
        eng_done = 0;
        rd_reg(1);
        rd_reg(K + 3);
        rd_reg(0);

        repeat (6) @(posedge HCLK);
        chk("sb_drained", exp_q.size(), 0);
        chk("starts_drained", start_q.size(), 0);
        summary();
        $finish;
    end

endmodule
